eeprom_arbiter: RTL and testbench

Request arbiter and sequencer in front of the `eeprom` SPI engine. It shares one EEPROM between two requesters, for example the host command path and a calibration loader, using round-robin arbitration. It issues exactly one single-cycle start pulse per transaction into the engine's idle state and returns read data or completion on a per-requester response pulse. It also enforces the EEPROM internal write-cycle time after every write, and recovers from a hung engine with a timeout.

---
 rtl/eeprom_arbiter.sv | 153 +++++++++++++++
 tb/tb_eeprom_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/eeprom_arbiter.sv
// Round-robin arbiter and sequencer sharing one EEPROM SPI engine between two
// requesters, with post-write cycle-time hold and hung-engine timeout.
module eeprom_arbiter #(
    parameter int TWC_CYC     = 500000,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [1:0]  req_wr,
    input  logic [15:0] req_addr0,
    input  logic [15:0] req_addr1,
    input  logic [15:0] req_wdata0,
    input  logic [15:0] req_wdata1,
    output logic [1:0]  rsp_valid,
    output logic        rsp_err,
    output logic [7:0]  rsp_rdata,
    output logic        busy,
    output logic [7:0]  err_cnt,
    output logic [31:0] addr_data_w,
    output logic        addr_data_w_en,
    output logic [15:0] addr_r,
    output logic        addr_r_en,
    input  logic [7:0]  data_r,
    input  logic        spi_ok
);

    localparam int TO_W   = $clog2(TIMEOUT_CYC);
    localparam int HOLD_W = $clog2(TWC_CYC + 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(TWC_CYC - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_OK, WR_HOLD} state_t;

    state_t            state_q;
    logic              last_grant_q;
    logic              idx_q;
    logic              wr_q;
    logic [TO_W-1:0]   to_cnt_q;
    logic [HOLD_W-1:0] hold_cnt_q;
    logic [1:0]        rsp_valid_q;
    logic              rsp_err_q;
    logic [7:0]        rsp_rdata_q;
    logic [7:0]        err_cnt_q;
    logic [31:0]       addr_data_w_q;
    logic              addr_data_w_en_q;
    logic [15:0]       addr_r_q;
    logic              addr_r_en_q;

    logic        grant_idx;
    logic        accept;
    logic        sel_wr;
    logic [15:0] sel_addr;
    logic [15:0] sel_wdata;

    // On a tie the requester that did not win last time gets the grant.
    always_comb begin
        grant_idx = (&req_valid) ? ~last_grant_q : req_valid[1];
        sel_wr    = req_wr[grant_idx];
        sel_addr  = grant_idx ? req_addr1  : req_addr0;
        sel_wdata = grant_idx ? req_wdata1 : req_wdata0;
    end

    // Ready is also held low while reset is asserted, so nothing can appear accepted.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ready
            assign req_ready[gi] = rst_n && (state_q == IDLE) && req_valid[gi]
                                   && (grant_idx == 1'(gi));
        end
    endgenerate

    assign accept = |(req_valid & req_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            last_grant_q     <= 1'b1;
            idx_q            <= 1'b0;
            wr_q             <= 1'b0;
            to_cnt_q         <= '0;
            hold_cnt_q       <= '0;
            rsp_valid_q      <= 2'b00;
            rsp_err_q        <= 1'b0;
            rsp_rdata_q      <= 8'h00;
            err_cnt_q        <= 8'h00;
            addr_data_w_q    <= 32'h0;
            addr_data_w_en_q <= 1'b0;
            addr_r_q         <= 16'h0;
            addr_r_en_q      <= 1'b0;
        end else begin
            addr_data_w_en_q <= 1'b0;
            addr_r_en_q      <= 1'b0;
            rsp_valid_q      <= 2'b00;
            rsp_err_q        <= 1'b0;
            rsp_rdata_q      <= 8'h00;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        idx_q            <= grant_idx;
                        wr_q             <= sel_wr;
                        last_grant_q     <= grant_idx;
                        addr_data_w_q    <= {sel_addr, sel_wdata};
                        addr_r_q         <= sel_addr;
                        addr_data_w_en_q <= sel_wr;
                        addr_r_en_q      <= ~sel_wr;
                        state_q          <= ISSUE;
                    end
                end
                ISSUE: begin
                    to_cnt_q <= '0;
                    state_q  <= WAIT_OK;
                end
                WAIT_OK: begin
                    to_cnt_q <= to_cnt_q + 1'b1;
                    // A completion in the final counted cycle still counts as success.
                    if (spi_ok) begin
                        rsp_valid_q[idx_q] <= 1'b1;
                        rsp_rdata_q        <= wr_q ? 8'h00 : data_r;
                        hold_cnt_q         <= '0;
                        state_q            <= wr_q ? WR_HOLD : IDLE;
                    end else if (to_cnt_q == TO_LAST) begin
                        rsp_valid_q[idx_q] <= 1'b1;
                        rsp_err_q          <= 1'b1;
                        if (err_cnt_q != 8'hFF) begin
                            err_cnt_q <= err_cnt_q + 8'd1;
                        end
                        state_q <= IDLE;
                    end
                end
                WR_HOLD: begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_q <= IDLE;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rsp_valid      = rsp_valid_q;
    assign rsp_err        = rsp_err_q;
    assign rsp_rdata      = rsp_rdata_q;
    assign busy           = (state_q != IDLE);
    assign err_cnt        = err_cnt_q;
    assign addr_data_w    = addr_data_w_q;
    assign addr_data_w_en = addr_data_w_en_q;
    assign addr_r         = addr_r_q;
    assign addr_r_en      = addr_r_en_q;

endmodule

// File: tb/tb_eeprom_arbiter.sv
// Directed bench for eeprom_arbiter: read, write with hold, contention, timeout,
// spi_ok/timeout collision and reset during the write hold.
module tb_eeprom_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_wr;
    logic [15:0] req_addr0, req_addr1, req_wdata0, req_wdata1;
    logic [1:0]  rsp_valid;
    logic        rsp_err;
    logic [7:0]  rsp_rdata;
    logic        busy;
    logic [7:0]  err_cnt;
    logic [31:0] addr_data_w;
    logic        addr_data_w_en;
    logic [15:0] addr_r;
    logic        addr_r_en;
    logic [7:0]  data_r;
    logic        spi_ok;

    int vectors     = 0;
    int miscompares = 0;

    eeprom_arbiter #(.TWC_CYC(100), .TIMEOUT_CYC(64)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_wr         (req_wr),
        .req_addr0      (req_addr0),
        .req_addr1      (req_addr1),
        .req_wdata0     (req_wdata0),
        .req_wdata1     (req_wdata1),
        .rsp_valid      (rsp_valid),
        .rsp_err        (rsp_err),
        .rsp_rdata      (rsp_rdata),
        .busy           (busy),
        .err_cnt        (err_cnt),
        .addr_data_w    (addr_data_w),
        .addr_data_w_en (addr_data_w_en),
        .addr_r         (addr_r),
        .addr_r_en      (addr_r_en),
        .data_r         (data_r),
        .spi_ok         (spi_ok)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [1:0] exp_g;
        logic       ready_seen;
        int         n0, n1;

        rst_n = 1'b0; req_valid = 2'b00; req_wr = 2'b00;
        req_addr0 = 16'h0; req_addr1 = 16'h0; req_wdata0 = 16'h0; req_wdata1 = 16'h0;
        data_r = 8'h00; spi_ok = 1'b0;

        // Reset values
        tick(); tick();
        req_valid = 2'b01;
        #1;
        chk("rst_ready", {30'd0, req_ready}, 0);
        chk("rst_rsp_valid", {30'd0, rsp_valid}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_err_cnt", {24'd0, err_cnt}, 0);
        chk("rst_addr_data_w", addr_data_w, 0);
        chk("rst_addr_r", {16'd0, addr_r}, 0);
        chk("rst_en", {30'd0, addr_r_en, addr_data_w_en}, 0);
        req_valid = 2'b00;
        tick();
        rst_n = 1'b1;
        tick();

        // Single read from requester 0
        req_wr = 2'b00; req_addr0 = 16'h0123; req_valid = 2'b01;
        #1;
        chk("rd_ready", {30'd0, req_ready}, 32'h1);
        tick();                                  // T+1
        req_valid = 2'b00;
        chk("rd_addr_r_en", {31'd0, addr_r_en}, 1);
        chk("rd_addr_r", {16'd0, addr_r}, 32'h0123);
        chk("rd_w_en", {31'd0, addr_data_w_en}, 0);
        chk("rd_busy", {31'd0, busy}, 1);
        tick();                                  // T+2
        chk("rd_en_1cyc", {31'd0, addr_r_en}, 0);
        tick();                                  // T+3 = S
        spi_ok = 1'b1; data_r = 8'hA5;
        tick();                                  // S+1
        spi_ok = 1'b0; data_r = 8'h00;
        chk("rd_rsp_valid", {30'd0, rsp_valid}, 32'h1);
        chk("rd_rdata", {24'd0, rsp_rdata}, 32'hA5);
        chk("rd_err", {31'd0, rsp_err}, 0);
        chk("rd_idle", {31'd0, busy}, 0);
        tick();
        chk("rd_rsp_pulse", {30'd0, rsp_valid}, 0);

        // Write from requester 1 with 100-cycle hold
        req_wr = 2'b10; req_addr1 = 16'h0040; req_wdata1 = 16'hBEEF; req_valid = 2'b10;
        #1;
        chk("wr_ready", {30'd0, req_ready}, 32'h2);
        tick();                                  // T+1
        req_valid = 2'b00;
        chk("wr_w_en", {31'd0, addr_data_w_en}, 1);
        chk("wr_addr_data_w", addr_data_w, 32'h0040BEEF);
        chk("wr_r_en", {31'd0, addr_r_en}, 0);
        tick();                                  // T+2
        chk("wr_en_1cyc", {31'd0, addr_data_w_en}, 0);
        spi_ok = 1'b1;
        tick();                                  // S+1
        spi_ok = 1'b0;
        chk("wr_rsp_valid", {30'd0, rsp_valid}, 32'h2);
        chk("wr_rdata", {24'd0, rsp_rdata}, 0);
        chk("wr_hold_busy", {31'd0, busy}, 1);

        // Both requesters wait through the hold, then contend
        req_wr = 2'b00; req_addr0 = 16'h1000; req_addr1 = 16'h2000; req_valid = 2'b11;
        ready_seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            #1;
            ready_seen = ready_seen | (|req_ready);
            tick();
        end
        chk("wr_hold_ready", {31'd0, ready_seen}, 0);

        n0 = 0; n1 = 0;
        for (int k = 0; k < 8; k++) begin
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            chk($sformatf("cont%0d_ready", k), {30'd0, req_ready}, {30'd0, exp_g});
            tick();                              // T+1
            if (exp_g == 2'b01) begin
                n0++;
                if (n0 == 4) req_valid[0] = 1'b0;
            end else begin
                n1++;
                if (n1 == 4) req_valid[1] = 1'b0;
            end
            chk($sformatf("cont%0d_addr_r", k), {16'd0, addr_r},
                (exp_g == 2'b01) ? 32'h1000 : 32'h2000);
            tick();                              // T+2
            spi_ok = 1'b1; data_r = 8'(k + 16);
            tick();                              // S+1
            spi_ok = 1'b0;
            chk($sformatf("cont%0d_rsp", k), {30'd0, rsp_valid}, {30'd0, exp_g});
            chk($sformatf("cont%0d_rdata", k), {24'd0, rsp_rdata}, 32'(k + 16));
        end
        #1;
        chk("cont_done_ready", {30'd0, req_ready}, 0);

        // Timeout: engine never answers
        req_addr0 = 16'h0055; data_r = 8'h77; req_valid = 2'b01;
        #1;
        chk("to_ready", {30'd0, req_ready}, 32'h1);
        tick();                                  // T+1
        req_valid = 2'b00;
        for (int i = 0; i < 64; i++) tick();     // T+65
        chk("to_early", {30'd0, rsp_valid}, 0);
        tick();                                  // T+66
        chk("to_rsp_valid", {30'd0, rsp_valid}, 32'h1);
        chk("to_rsp_err", {31'd0, rsp_err}, 1);
        chk("to_rdata", {24'd0, rsp_rdata}, 0);
        chk("to_err_cnt", {24'd0, err_cnt}, 1);
        tick();
        spi_ok = 1'b1;                           // stale completion in IDLE
        tick();
        spi_ok = 1'b0;
        chk("stale_rsp", {30'd0, rsp_valid}, 0);
        chk("stale_err_cnt", {24'd0, err_cnt}, 1);
        chk("stale_busy", {31'd0, busy}, 0);

        // Normal read after the timeout
        req_addr1 = 16'h0099; req_valid = 2'b10;
        #1;
        chk("post_to_ready", {30'd0, req_ready}, 32'h2);
        tick();
        req_valid = 2'b00;
        chk("post_to_addr_r", {16'd0, addr_r}, 32'h0099);
        chk("post_to_r_en", {31'd0, addr_r_en}, 1);
        tick();
        spi_ok = 1'b1; data_r = 8'h3C;
        tick();
        spi_ok = 1'b0;
        chk("post_to_rsp", {30'd0, rsp_valid}, 32'h2);
        chk("post_to_rdata", {24'd0, rsp_rdata}, 32'h3C);
        chk("post_to_err", {31'd0, rsp_err}, 0);

        // spi_ok in the last counted cycle wins over the timeout
        req_addr0 = 16'h0066; req_valid = 2'b01;
        #1;
        tick();                                  // T+1
        req_valid = 2'b00;
        for (int i = 0; i < 64; i++) tick();     // T+65
        spi_ok = 1'b1; data_r = 8'h5A;
        tick();                                  // T+66
        spi_ok = 1'b0;
        chk("coll_rsp", {30'd0, rsp_valid}, 32'h1);
        chk("coll_err", {31'd0, rsp_err}, 0);
        chk("coll_rdata", {24'd0, rsp_rdata}, 32'h5A);
        chk("coll_err_cnt", {24'd0, err_cnt}, 1);

        // Reset asserted during the write hold
        req_wr = 2'b01; req_addr0 = 16'h0010; req_wdata0 = 16'h1234; req_valid = 2'b01;
        #1;
        tick();
        req_valid = 2'b00;
        tick();
        spi_ok = 1'b1;
        tick();
        spi_ok = 1'b0;
        chk("rw_rsp", {30'd0, rsp_valid}, 32'h1);
        for (int i = 0; i < 5; i++) tick();
        chk("rw_hold_busy", {31'd0, busy}, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rw_async_busy", {31'd0, busy}, 0);
        chk("rw_async_addr_data_w", addr_data_w, 0);
        chk("rw_async_addr_r", {16'd0, addr_r}, 0);
        chk("rw_async_err_cnt", {24'd0, err_cnt}, 0);
        chk("rw_async_rsp", {30'd0, rsp_valid}, 0);
        tick(); tick();
        chk("rw_no_rsp", {30'd0, rsp_valid}, 0);
        rst_n = 1'b1;
        req_wr = 2'b00; req_addr0 = 16'h0ABC; req_valid = 2'b11;
        #1;
        chk("rw_tie_ready", {30'd0, req_ready}, 32'h1);
        tick();
        req_valid = 2'b00;
        chk("rw_r_en", {31'd0, addr_r_en}, 1);
        chk("rw_addr_r", {16'd0, addr_r}, 32'h0ABC);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
